dl_sdram_writer: RTL

//  Packs the data_io ROM download byte stream (ioctl_wr/addr/dout) into 16-bit SDRAM word writes.

---
 rtl/dl_sdram_writer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dl_sdram_writer.sv
// Packs the data_io download byte stream into 16-bit SDRAM word writes through a small
// write queue, driving a toggle req/ack port and reporting drain completion.
module dl_sdram_writer #(
    parameter int unsigned AW         = 23,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [AW-1:0] sdram_a,
    output logic [1:0]    sdram_ds,
    output logic [15:0]   sdram_d,
    output logic          sdram_we,
    output logic          busy,
    output logic          overflow,
    output logic          done,
    output logic          rom_loaded
);

    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef struct packed {
        logic [AW-1:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
    } word_t;

    typedef enum logic [1:0] {DL_IDLE, DL_ACTIVE, DL_DRAIN} dl_state_t;
    typedef enum logic [1:0] {S_RESYNC, S_IDLE, S_WAIT}     snd_state_t;

    dl_state_t  r_dl_state;
    snd_state_t r_s_state;
    logic       r_dl_prev;
    word_t      r_pend;
    logic       r_pend_v;
    word_t      r_fifo [FIFO_DEPTH];
    logic [PW:0] r_wp;
    logic [PW:0] r_rp;
    logic       r_req;
    logic       r_we;
    word_t      r_out;
    logic       r_overflow;
    logic       r_done;
    logic       r_rom_loaded;

    logic          w_rise;
    logic          w_flush;
    logic          w_wr;
    logic [AW-1:0] w_wa;
    logic          w_lane;
    logic          w_merge;
    word_t         w_mrg;
    word_t         w_new;
    logic          w_push;
    word_t         w_push_word;
    logic          w_pend_nv;
    word_t         w_pend_n;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_unused;

    assign w_unused = &{1'b0, ioctl_addr[24:AW+1]};

    assign w_rise  = ioctl_download & ~r_dl_prev;
    assign w_flush = (r_dl_state == DL_ACTIVE) & ~ioctl_download;
    assign w_wr    = ioctl_wr & ioctl_download;
    assign w_wa    = ioctl_addr[AW:1];
    assign w_lane  = ioctl_addr[0];
    assign w_merge = r_pend_v & (r_pend.a == w_wa) & ~r_pend.ds[w_lane];

    always_comb begin
        w_mrg   = r_pend;
        w_new.a = w_wa;
        if (w_lane) begin
            w_mrg.ds[1]    = 1'b1;
            w_mrg.d[15:8]  = ioctl_dout;
            w_new.ds       = 2'b10;
            w_new.d        = {ioctl_dout, 8'h00};
        end else begin
            w_mrg.ds[0]    = 1'b1;
            w_mrg.d[7:0]   = ioctl_dout;
            w_new.ds       = 2'b01;
            w_new.d        = {8'h00, ioctl_dout};
        end
    end

    // Byte merge/push decision; the end-of-download flush sees the post-merge pending word.
    always_comb begin
        w_push      = 1'b0;
        w_push_word = r_pend;
        w_pend_nv   = r_pend_v;
        w_pend_n    = r_pend;
        if (w_wr) begin
            if (w_merge) begin
                w_pend_n = w_mrg;
                if (w_mrg.ds == 2'b11) begin
                    w_push      = 1'b1;
                    w_push_word = w_mrg;
                    w_pend_nv   = 1'b0;
                end
            end else begin
                w_push      = r_pend_v;
                w_push_word = r_pend;
                w_pend_n    = w_new;
                w_pend_nv   = 1'b1;
            end
        end
        if (w_flush && w_pend_nv && !w_push) begin
            w_push      = 1'b1;
            w_push_word = w_pend_n;
            w_pend_nv   = 1'b0;
        end
    end

    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign w_pop     = (r_s_state == S_WAIT) && (sdram_ack == r_req);
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
        end else begin
            r_pend   <= w_pend_n;
            r_pend_v <= w_pend_nv;
            if (w_push_ok) r_wp <= r_wp + PTR_ONE;
            if (w_pop)     r_rp <= r_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push_ok) r_fifo[r_wp[PW-1:0]] <= w_push_word;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_s_state <= S_RESYNC;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_out     <= '0;
        end else begin
            case (r_s_state)
                S_RESYNC: begin
                    r_req     <= sdram_ack;
                    r_s_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (!w_empty && (sdram_ack == r_req)) begin
                        r_out     <= r_fifo[r_rp[PW-1:0]];
                        r_req     <= ~r_req;
                        r_we      <= 1'b1;
                        r_s_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdram_ack == r_req) begin
                        r_we      <= 1'b0;
                        r_s_state <= S_IDLE;
                    end
                end
                default: r_s_state <= S_RESYNC;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_state   <= DL_IDLE;
            r_dl_prev    <= 1'b0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_rom_loaded <= 1'b0;
        end else begin
            r_dl_prev <= ioctl_download;
            r_done    <= 1'b0;
            if (w_rise) begin
                r_overflow   <= 1'b0;
                r_rom_loaded <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_dl_state)
                DL_IDLE: begin
                    if (w_rise) r_dl_state <= DL_ACTIVE;
                end
                DL_ACTIVE: begin
                    if (!ioctl_download) r_dl_state <= DL_DRAIN;
                end
                DL_DRAIN: begin
                    if (w_rise) begin
                        r_dl_state <= DL_ACTIVE;
                    end else if (w_empty && (r_s_state == S_IDLE)) begin
                        r_dl_state   <= DL_IDLE;
                        r_done       <= 1'b1;
                        r_rom_loaded <= 1'b1;
                    end
                end
                default: r_dl_state <= DL_IDLE;
            endcase
        end
    end

    assign sdram_req  = r_req;
    assign sdram_we   = r_we;
    assign sdram_a    = r_out.a;
    assign sdram_ds   = r_out.ds;
    assign sdram_d    = r_out.d;
    assign busy       = (r_dl_state != DL_IDLE) | r_pend_v | ~w_empty | r_we;
    assign overflow   = r_overflow;
    assign done       = r_done;
    assign rom_loaded = r_rom_loaded;

endmodule
